// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, false-start rejection and a receive FIFO.
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int BAUD_DIV   = 2604,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 clr_rdy,
  input  logic                 clr_err,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
  output logic                 par_err,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 frm_err,
  output logic                 ovr_err,
  output logic                 busy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  // Loads are one less than the period so each state lasts exactly that many clks.
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);
  localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  logic                 r_rx_meta;
  logic                 r_rx_sync;
  state_t               r_state;
  logic [CW-1:0]        r_baud_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [NW-1:0]        r_count;
  logic                 r_frm_err;
  logic                 r_ovr_err;

  logic w_tick;
  logic w_stop_tick;
  logic w_par_ok;
  logic w_push_req;
  logic w_frm_set;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_ovr_set;

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_par_err;
  logic w_par_mismatch;
  logic w_par_set;

  assign w_par_mismatch = ((^r_shift) ^ r_rx_sync) != parity_odd;
  assign w_par_set      = (r_state == S_PARITY) && w_tick && w_par_mismatch;
  assign w_par_ok       = !r_par_bad;
`else
  assign w_par_ok       = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_tick      = (r_baud_cnt == '0);
  assign w_stop_tick = (r_state == S_STOP) && w_tick;
  assign w_push_req  = w_stop_tick && r_rx_sync && w_par_ok;
  assign w_frm_set   = w_stop_tick && !r_rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bad  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_rx_sync) begin
            r_state    <= S_START;
            r_baud_cnt <= HALF_LOAD;
          end
        end
        S_START: begin
          if (!w_tick) begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end else if (r_rx_sync) begin
            r_state <= S_IDLE;
          end else begin
            r_state    <= S_DATA;
            r_baud_cnt <= FULL_LOAD;
            r_bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
            r_par_bad  <= 1'b0;
`endif
          end
        end
        S_DATA: begin
          if (!w_tick) begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end else begin
            r_shift    <= {r_rx_sync, r_shift[DATA_BITS-1:1]};
            r_baud_cnt <= FULL_LOAD;
            if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (!w_tick) begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end else begin
            r_par_bad  <= w_par_mismatch;
            r_baud_cnt <= FULL_LOAD;
            r_state    <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (!w_tick) begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end else begin
            r_state <= r_rx_sync ? S_IDLE : S_BREAK;
          end
        end
        S_BREAK: begin
          if (r_rx_sync) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A full FIFO still accepts a word when a pop frees a slot in the same cycle.
  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = clr_rdy && (r_count != '0);
  assign w_push    = w_push_req && (!w_full || w_pop);
  assign w_ovr_set = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frm_err <= 1'b0;
      r_ovr_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      r_frm_err <= w_frm_set | (r_frm_err & ~clr_err);
      r_ovr_err <= w_ovr_set | (r_ovr_err & ~clr_err);
`ifdef UART_RX_PARITY_EN
      r_par_err <= w_par_set | (r_par_err & ~clr_err);
`endif
    end
  end

  assign rx_data = r_mem[r_rd_ptr];
  assign rdy     = (r_count != '0);
  assign frm_err = r_frm_err;
  assign ovr_err = r_ovr_err;
  assign busy    = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign par_err = r_par_err;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: default-rate latency, FIFO/overrun, glitch,
// framing, simultaneous push/pop and a 7-bit build; parity cases under UART_RX_PARITY_EN.
module tb_uart_rx_fifo;

  localparam int BA = 2604;
  localparam int BF = 16;
  localparam int BS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LAT_A     = 2 + BA / 2 + (8 + 1 + PB) * BA + 1;
  localparam int STOP_EDGE = 3 + BF / 2 + (8 + 1 + PB) * BF;

  logic clk = 1'b0;
  logic rst_n;
  logic par_odd = 1'b0;

  logic rxA, clrRdyA, clrErrA, rdyA, frmA, ovrA, busyA;
  logic rxF, clrRdyF, clrErrF, rdyF, frmF, ovrF, busyF;
  logic rxS, clrRdyS, clrErrS, rdyS, frmS, ovrS, busyS;
  logic [7:0] dataA, dataF;
  logic [6:0] dataS;
`ifdef UART_RX_PARITY_EN
  logic parA, parF, parS;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_BITS(8), .BAUD_DIV(BA), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .RX(rxA), .clr_rdy(clrRdyA), .clr_err(clrErrA),
`ifdef UART_RX_PARITY_EN
    .parity_odd(par_odd), .par_err(parA),
`endif
    .rx_data(dataA), .rdy(rdyA), .frm_err(frmA), .ovr_err(ovrA), .busy(busyA));

  uart_rx_fifo #(.DATA_BITS(8), .BAUD_DIV(BF), .FIFO_DEPTH(4)) u_dut_f (
    .clk(clk), .rst_n(rst_n), .RX(rxF), .clr_rdy(clrRdyF), .clr_err(clrErrF),
`ifdef UART_RX_PARITY_EN
    .parity_odd(par_odd), .par_err(parF),
`endif
    .rx_data(dataF), .rdy(rdyF), .frm_err(frmF), .ovr_err(ovrF), .busy(busyF));

  uart_rx_fifo #(.DATA_BITS(7), .BAUD_DIV(BS), .FIFO_DEPTH(4)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .RX(rxS), .clr_rdy(clrRdyS), .clr_err(clrErrS),
`ifdef UART_RX_PARITY_EN
    .parity_odd(par_odd), .par_err(parS),
`endif
    .rx_data(dataS), .rdy(rdyS), .frm_err(frmS), .ovr_err(ovrS), .busy(busyS));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int which, input logic v);
    case (which)
      0:       rxA = v;
      1:       rxF = v;
      default: rxS = v;
    endcase
  endtask

  // Caller is positioned 1 time unit after a rising edge.
  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input int baud, input logic stop_bit, input logic bad_par);
    set_rx(which, 1'b0);
    wait_clks(baud);
    for (int i = 0; i < nbits; i++) begin
      set_rx(which, data[i]);
      wait_clks(baud);
    end
`ifdef UART_RX_PARITY_EN
    begin
      logic p;
      p = bad_par;
      for (int i = 0; i < nbits; i++) p = p ^ data[i];
      set_rx(which, p);
      wait_clks(baud);
    end
`endif
    set_rx(which, stop_bit);
    wait_clks(baud);
  endtask

  task automatic pop_f();
    clrRdyF = 1'b1;
    wait_clks(1);
    clrRdyF = 1'b0;
  endtask

  task automatic clr_err_f();
    clrErrF = 1'b1;
    wait_clks(1);
    clrErrF = 1'b0;
  endtask

  initial begin
    rxA = 1'b1; rxF = 1'b1; rxS = 1'b1;
    clrRdyA = 1'b0; clrErrA = 1'b0;
    clrRdyF = 1'b0; clrErrF = 1'b0;
    clrRdyS = 1'b0; clrErrS = 1'b0;
    rst_n = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(2);
    check("rst_rdy",  rdyA,  0);
    check("rst_frm",  frmA,  0);
    check("rst_ovr",  ovrA,  0);
    check("rst_busy", busyA, 0);
    check("rst_busy_f", busyF, 0);

    // Default rate: exact latency to rdy
    fork
      send_frame(0, 9'h0A5, 8, BA, 1'b1, 1'b0);
      begin
        repeat (LAT_A - 1) @(posedge clk);
        #1;
        check("lat_before", rdyA, 0);
        @(posedge clk);
        #1;
        check("lat_at", rdyA, 1);
      end
    join
    check("a5_data", dataA, 8'hA5);
    check("a5_frm",  frmA, 0);
    clrRdyA = 1'b1;
    wait_clks(1);
    clrRdyA = 1'b0;
    check("a5_pop_rdy", rdyA, 0);

    // Five back-to-back frames into a 4-deep FIFO
    for (int v = 1; v <= 5; v++) send_frame(1, 9'(v), 8, BF, 1'b1, 1'b0);
    wait_clks(2);
    check("ovf_rdy", rdyF, 1);
    check("ovf_ovr", ovrF, 1);
    check("ovf_frm", frmF, 0);
`ifdef UART_RX_PARITY_EN
    check("ovf_par", parF, 0);
`endif
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovf_head%0d", i), dataF, 32'(i));
      pop_f();
    end
    check("ovf_empty", rdyF, 0);

    // Glitch shorter than half a bit
    clr_err_f();
    check("clr_ovr", ovrF, 0);
    rxF = 1'b0;
    wait_clks(BF / 4);
    rxF = 1'b1;
    check("glitch_busy", busyF, 1);
    wait_clks(20);
    check("glitch_idle", busyF, 0);
    check("glitch_rdy",  rdyF, 0);
    check("glitch_frm",  frmF, 0);

    // Bad stop bit followed by a held-low line
    send_frame(1, 9'h03C, 8, BF, 1'b0, 1'b0);
    wait_clks(3 * (10 + PB) * BF);
    check("brk_frm",  frmF, 1);
    check("brk_busy", busyF, 1);
    check("brk_rdy",  rdyF, 0);
    rxF = 1'b1;
    wait_clks(4);
    check("brk_release", busyF, 0);
    send_frame(1, 9'h07E, 8, BF, 1'b1, 1'b0);
    wait_clks(2);
    check("after_brk_rdy",  rdyF, 1);
    check("after_brk_data", dataF, 8'h7E);
    check("after_brk_frm",  frmF, 1);
    pop_f();
    clr_err_f();
    check("frm_cleared", frmF, 0);

    // Pop in the stop-sample cycle of a frame arriving at a full FIFO
    send_frame(1, 9'h011, 8, BF, 1'b1, 1'b0);
    send_frame(1, 9'h022, 8, BF, 1'b1, 1'b0);
    send_frame(1, 9'h033, 8, BF, 1'b1, 1'b0);
    send_frame(1, 9'h044, 8, BF, 1'b1, 1'b0);
    fork
      send_frame(1, 9'h099, 8, BF, 1'b1, 1'b0);
      begin
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1;
        clrRdyF = 1'b1;
        wait_clks(1);
        clrRdyF = 1'b0;
      end
    join
    wait_clks(1);
    check("pp_ovr", ovrF, 0);
    check("pp_head0", dataF, 8'h22); pop_f();
    check("pp_head1", dataF, 8'h33); pop_f();
    check("pp_head2", dataF, 8'h44); pop_f();
    check("pp_tail",  dataF, 8'h99); pop_f();
    check("pp_empty", rdyF, 0);

    // Seven data bits
    send_frame(2, 9'h055, 7, BS, 1'b1, 1'b0);
    wait_clks(2);
    check("s7_rdy",  rdyS, 1);
    check("s7_data", dataS, 7'h55);
    check("s7_frm",  frmS, 0);
    clrRdyS = 1'b1;
    wait_clks(1);
    clrRdyS = 1'b0;
`ifdef UART_RX_PARITY_EN
    send_frame(2, 9'h055, 7, BS, 1'b1, 1'b1);
    wait_clks(2);
    check("par_err", parS, 1);
    check("par_drop", rdyS, 0);
    check("par_frm", frmS, 0);
`endif

    // Asynchronous reset in the middle of a frame
    send_frame(1, 9'h012, 8, BF, 1'b1, 1'b0);
    fork
      send_frame(1, 9'h05A, 8, BF, 1'b1, 1'b0);
      begin
        wait_clks(40);
        check("mid_busy", busyF, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busyF, 0);
        check("arst_rdy",  rdyF, 0);
      end
    join
    rst_n = 1'b1;
    wait_clks(2);
    check("arst_after_rdy", rdyF, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
